// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: bounces a SIZE x SIZE sprite around the screen, one
// pixel per rate-divider tick. Each step erases the old sprite, moves it and
// redraws it, streaming every pixel over a valid/ready plot interface.
module sprite_motion_ctrl #(
   parameter int X_WIDTH = 8,
   parameter int Y_WIDTH = 7,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119,
   parameter int SIZE    = 4,
   parameter int X_INIT  = 0,
   parameter int Y_INIT  = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tick,
   input  logic               run,
   input  logic [2:0]         fg_colour,
   input  logic [2:0]         bg_colour,
   output logic [X_WIDTH-1:0] plot_x,
   output logic [Y_WIDTH-1:0] plot_y,
   output logic [2:0]         plot_colour,
   output logic               plot_valid,
   input  logic               plot_ready,
   output logic               busy,
   output logic [X_WIDTH-1:0] x_pos,
   output logic [Y_WIDTH-1:0] y_pos,
   output logic               missed_tick
);

   typedef enum logic [2:0] {S_INIT_DRAW, S_IDLE, S_ERASE, S_MOVE, S_DRAW} state_t;

   // Largest top-left coordinate that keeps the whole sprite on screen.
   localparam logic [X_WIDTH-1:0] X_RIGHT  = X_WIDTH'(X_MAX - SIZE + 1);
   localparam logic [Y_WIDTH-1:0] Y_BOTTOM = Y_WIDTH'(Y_MAX - SIZE + 1);
   localparam logic [2:0]         LAST     = 3'(SIZE - 1);

   state_t               state_q, state_d;
   logic [X_WIDTH-1:0]   x_q, x_d, x_mv, plot_x_q, plot_x_d;
   logic [Y_WIDTH-1:0]   y_q, y_d, y_mv, plot_y_q, plot_y_d;
   logic                 dir_x_q, dir_x_d, dir_x_mv;   // 1 = moving +1
   logic                 dir_y_q, dir_y_d, dir_y_mv;
   logic [2:0]           dx_q, dx_d, dy_q, dy_d, nx, ny;
   logic [2:0]           plot_colour_q, plot_colour_d, phase_colour;
   logic                 plot_valid_q, plot_valid_d;
   logic                 pending_q, pending_d, missed_q, missed_d, tick_q;
   logic                 tick_edge, xfer, last_px, go;

   assign tick_edge    = tick & ~tick_q & run;
   assign xfer         = plot_valid_q & plot_ready;
   assign last_px      = (dx_q == LAST) && (dy_q == LAST);
   assign go           = tick_edge | pending_q;
   assign phase_colour = (state_q == S_ERASE) ? bg_colour : fg_colour;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_INIT_DRAW;
      else       state_q <= state_d;
   end

   // Next-state: pixel phases end on the handshake of their last pixel
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT_DRAW: if (xfer && last_px) state_d = S_IDLE;
         S_IDLE:      if (go)              state_d = S_ERASE;
         S_ERASE:     if (xfer && last_px) state_d = S_MOVE;
         S_MOVE:                           state_d = S_DRAW;
         S_DRAW:      if (xfer && last_px) state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   // Bounce arithmetic: reverse at an edge by stepping back the other way
   always_comb begin
      x_mv = x_q; dir_x_mv = dir_x_q;
      y_mv = y_q; dir_y_mv = dir_y_q;
      if (dir_x_q && x_q == X_RIGHT)  begin dir_x_mv = 1'b0; x_mv = x_q - X_WIDTH'(1); end
      else if (!dir_x_q && x_q == '0) begin dir_x_mv = 1'b1; x_mv = X_WIDTH'(1); end
      else if (dir_x_q)               x_mv = x_q + X_WIDTH'(1);
      else                            x_mv = x_q - X_WIDTH'(1);
      if (dir_y_q && y_q == Y_BOTTOM) begin dir_y_mv = 1'b0; y_mv = y_q - Y_WIDTH'(1); end
      else if (!dir_y_q && y_q == '0) begin dir_y_mv = 1'b1; y_mv = Y_WIDTH'(1); end
      else if (dir_y_q)               y_mv = y_q + Y_WIDTH'(1);
      else                            y_mv = y_q - Y_WIDTH'(1);
   end

   // Datapath outputs: pixel scan, position update, tick queueing
   always_comb begin
      x_d = x_q; y_d = y_q; dir_x_d = dir_x_q; dir_y_d = dir_y_q;
      dx_d = dx_q; dy_d = dy_q;
      plot_valid_d = plot_valid_q; plot_x_d = plot_x_q;
      plot_y_d = plot_y_q; plot_colour_d = plot_colour_q;
      pending_d = pending_q; missed_d = missed_q;
      // Row-major successor of the current scan offset
      if (dx_q == LAST) begin nx = '0;           ny = dy_q + 3'd1; end
      else              begin nx = dx_q + 3'd1;  ny = dy_q;        end
      case (state_q)
         S_IDLE: if (go) begin
            // First erase pixel is presented in the cycle right after the edge
            pending_d = 1'b0;
            plot_valid_d = 1'b1; plot_x_d = x_q; plot_y_d = y_q;
            plot_colour_d = bg_colour; dx_d = '0; dy_d = '0;
         end
         S_MOVE: begin
            x_d = x_mv; y_d = y_mv; dir_x_d = dir_x_mv; dir_y_d = dir_y_mv;
            plot_valid_d = 1'b1; plot_x_d = x_mv; plot_y_d = y_mv;
            plot_colour_d = fg_colour;
         end
         default: begin
            if (!plot_valid_q) begin
               // Only reached on entry to INIT_DRAW after reset
               plot_valid_d = 1'b1;
               plot_x_d = x_q + X_WIDTH'(dx_q); plot_y_d = y_q + Y_WIDTH'(dy_q);
               plot_colour_d = phase_colour;
            end else if (xfer) begin
               if (last_px) begin
                  plot_valid_d = 1'b0; dx_d = '0; dy_d = '0;
               end else begin
                  dx_d = nx; dy_d = ny;
                  plot_x_d = x_q + X_WIDTH'(nx); plot_y_d = y_q + Y_WIDTH'(ny);
                  plot_colour_d = phase_colour;
               end
            end
         end
      endcase
      // One tick may wait while busy; anything beyond that is lost and flagged
      if (tick_edge && state_q != S_IDLE) begin
         if (pending_q) missed_d  = 1'b1;
         else           pending_d = 1'b1;
      end
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= X_WIDTH'(X_INIT); y_q <= Y_WIDTH'(Y_INIT);
         dir_x_q <= 1'b1; dir_y_q <= 1'b1;
         dx_q <= '0; dy_q <= '0;
         plot_valid_q <= 1'b0; plot_x_q <= '0; plot_y_q <= '0; plot_colour_q <= '0;
         pending_q <= 1'b0; missed_q <= 1'b0; tick_q <= 1'b0;
      end else begin
         x_q <= x_d; y_q <= y_d; dir_x_q <= dir_x_d; dir_y_q <= dir_y_d;
         dx_q <= dx_d; dy_q <= dy_d;
         plot_valid_q <= plot_valid_d; plot_x_q <= plot_x_d;
         plot_y_q <= plot_y_d; plot_colour_q <= plot_colour_d;
         pending_q <= pending_d; missed_q <= missed_d; tick_q <= tick;
      end
   end

   assign plot_x      = plot_x_q;
   assign plot_y      = plot_y_q;
   assign plot_colour = plot_colour_q;
   assign plot_valid  = plot_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign x_pos       = x_q;
   assign y_pos       = y_q;
   assign missed_tick = missed_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus pushes the pixels a
// step should produce; a monitor pops and compares every handshaken pixel.
module tb_sprite_motion_ctrl;
   localparam int X_WIDTH = 8, Y_WIDTH = 7, X_MAX = 159, Y_MAX = 119, SIZE = 4;

   logic clock = 1'b0;
   logic reset, tick, run, plot_ready, plot_valid, busy, missed_tick;
   logic [2:0] fg_colour, bg_colour, plot_colour;
   logic [X_WIDTH-1:0] plot_x, x_pos;
   logic [Y_WIDTH-1:0] plot_y, y_pos;

   sprite_motion_ctrl dut (
      .clock(clock), .reset(reset), .tick(tick), .run(run),
      .fg_colour(fg_colour), .bg_colour(bg_colour),
      .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
      .plot_valid(plot_valid), .plot_ready(plot_ready), .busy(busy),
      .x_pos(x_pos), .y_pos(y_pos), .missed_tick(missed_tick));

   always #5 clock = ~clock;

   typedef struct packed {
      logic [X_WIDTH-1:0] x;
      logic [Y_WIDTH-1:0] y;
      logic [2:0]         c;
   } px_t;

   px_t exp_q[$];
   int  tests = 0, fails = 0, px_seen = 0;
   int  mx, my, mdx, mdy;       // reference sprite position and direction
   int  ready_mode = 0;         // 0 always, 1 random, 2 pattern 1,0,0,1, 3 never
   int  pidx = 0;
   int  bc;
   logic [3:0] pat = 4'b1001;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_sprite(input int bx, input int by, input logic [2:0] c);
      px_t p;
      for (int dy = 0; dy < SIZE; dy++)
         for (int dx = 0; dx < SIZE; dx++) begin
            p.x = X_WIDTH'(bx + dx); p.y = Y_WIDTH'(by + dy); p.c = c;
            exp_q.push_back(p);
         end
   endtask

   // One step: erase at old spot, move one pixel diagonally (reversing any
   // axis that would push the sprite off screen), draw at new spot.
   task automatic model_step();
      int nx, ny;
      push_sprite(mx, my, bg_colour);
      nx = mx + mdx;
      if (nx < 0 || nx > X_MAX - SIZE + 1) begin mdx = -mdx; nx = mx + mdx; end
      ny = my + mdy;
      if (ny < 0 || ny > Y_MAX - SIZE + 1) begin mdy = -mdy; ny = my + mdy; end
      mx = nx; my = ny;
      push_sprite(mx, my, fg_colour);
   endtask

   task automatic model_reset();
      mx = 0; my = 0; mdx = 1; mdy = 1;
   endtask

   task automatic pulse();
      @(posedge clock); #1 tick = 1'b1;
      @(posedge clock); #1 tick = 1'b0;
   endtask

   // Waits until busy has been low for 3 consecutive cycles, counting busy cycles
   task automatic wait_quiet(input int budget, output int busy_cycles);
      int quiet;
      quiet = 0; busy_cycles = 0;
      for (int i = 0; i < budget && quiet < 3; i++) begin
         @(negedge clock);
         if (busy) begin busy_cycles++; quiet = 0; end
         else quiet++;
      end
      if (quiet < 3) begin
         tests++; fails++;
         $display("FAIL timeout: busy still %0b after %0d cycles", busy, budget);
      end
   endtask

   task automatic check_settled(input string name);
      check({name, "_x"}, 32'(x_pos), 32'(mx));
      check({name, "_y"}, 32'(y_pos), 32'(my));
      check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // plot_ready driver
   always @(posedge clock) begin
      #1;
      case (ready_mode)
         0: plot_ready = 1'b1;
         1: plot_ready = ($urandom_range(0, 3) != 0);
         2: begin plot_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
         default: plot_ready = 1'b0;
      endcase
   end

   // Monitor: compares handshaken pixels and checks stability under stall
   logic stalled = 1'b0;
   px_t  held, mon_e;
   always @(negedge clock) begin
      if (reset) stalled = 1'b0;
      else begin
         if (stalled)
            check("stall_hold", 32'({plot_valid, plot_x, plot_y, plot_colour}),
                  32'({1'b1, held}));
         if (plot_valid && plot_ready) begin
            px_seen++;
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_pixel: got (%0d,%0d,c%0d), expected none",
                        plot_x, plot_y, plot_colour);
            end else begin
               mon_e = exp_q.pop_front();
               check("pixel", 32'({plot_x, plot_y, plot_colour}), 32'(mon_e));
            end
         end
         stalled = plot_valid && !plot_ready;
         held = {plot_x, plot_y, plot_colour};
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; tick = 1'b0; run = 1'b1; plot_ready = 1'b1;
      fg_colour = 3'd5; bg_colour = 3'd0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      model_reset(); px_seen = 0;
      push_sprite(mx, my, fg_colour);
      @(negedge clock);
      check("rst_valid", 32'(plot_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_x", 32'(x_pos), 32'd0);
      check("rst_y", 32'(y_pos), 32'd0);
      check("rst_missed", 32'(missed_tick), 32'd0);
      wait_quiet(200, bc);
      check("init_px_count", 32'(px_seen), 32'd16);
      check("init_q_empty", 32'(exp_q.size()), 32'd0);

      // Single step with plot_ready held high: exact busy window
      fg_colour = 3'd2; bg_colour = 3'd7;
      model_step(); pulse();
      wait_quiet(200, bc);
      check("step_busy_cycles", 32'(bc), 32'd33);
      check_settled("step1");

      // Stall pattern 1,0,0,1 on plot_ready
      ready_mode = 2;
      fg_colour = 3'($urandom_range(0, 7)); bg_colour = 3'($urandom_range(0, 7));
      model_step(); pulse();
      wait_quiet(400, bc);
      check_settled("stall_step");

      // Long random walk: hits the right, bottom, left and top edges
      ready_mode = 1;
      for (int s = 0; s < 316; s++) begin
         fg_colour = 3'($urandom_range(0, 7)); bg_colour = 3'($urandom_range(0, 7));
         model_step(); pulse();
         wait_quiet(400, bc);
         check("walk_x", 32'(x_pos), 32'(mx));
         check("walk_y", 32'(y_pos), 32'(my));
      end
      check("walk_q_empty", 32'(exp_q.size()), 32'd0);

      // Extra edges during a step: one queued, the rest dropped and flagged
      ready_mode = 0;
      model_step(); model_step();
      pulse(); pulse(); pulse(); pulse();
      wait_quiet(500, bc);
      check("missed_set", 32'(missed_tick), 32'd1);
      check_settled("pending");

      // Tick held high yields a single step
      model_step();
      @(posedge clock); #1 tick = 1'b1;
      repeat (50) @(posedge clock);
      #1 tick = 1'b0;
      wait_quiet(300, bc);
      check_settled("held");

      // run=0: edges ignored
      run = 1'b0;
      pulse(); pulse(); pulse();
      wait_quiet(50, bc);
      check("run0_busy", 32'(bc), 32'd0);
      check_settled("run0");
      run = 1'b1;

      // Reset in the middle of DRAW abandons the step and redraws at origin
      model_step(); pulse();
      repeat (20) @(negedge clock);
      check("mid_draw_busy", 32'(busy), 32'd1);
      @(posedge clock); #1 reset = 1'b1;
      exp_q.delete();
      @(posedge clock); #1 reset = 1'b0;
      model_reset(); px_seen = 0;
      push_sprite(mx, my, fg_colour);
      @(negedge clock);
      check("rst2_valid", 32'(plot_valid), 32'd0);
      check("rst2_busy", 32'(busy), 32'd1);
      check("rst2_missed", 32'(missed_tick), 32'd0);
      wait_quiet(200, bc);
      check("rst2_px_count", 32'(px_seen), 32'd16);
      check_settled("rst2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Consumes the one-cycle tick produced by the team's rate divider and advances a square sprite one pixel per tick in x and y, bouncing off the screen edges. Each step erases the sprite at its old position, updates the position, and redraws it. All pixels go out over a valid/ready plot interface to the downstream VGA plotter. A tick that arrives mid-step is queued (depth 1); further ticks are dropped and flagged.

Parameters:
X_WIDTH, 8, width of x coordinates
Y_WIDTH, 7, width of y coordinates
X_MAX, 159, rightmost legal pixel column
Y_MAX, 119, bottom legal pixel row
SIZE, 4, sprite edge length in pixels (1..8)
X_INIT, 0, x of sprite top-left after reset
Y_INIT, 0, y of sprite top-left after reset

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
tick  in  1  step request from rate divider; acted on at its rising edge only
run  in  1  1 = accept ticks; 0 = edges ignored (not queued)
fg_colour  in  3  sprite colour
bg_colour  in  3  erase colour
plot_x  out  X_WIDTH  pixel column
plot_y  out  Y_WIDTH  pixel row
plot_colour  out  3  pixel colour
plot_valid  out  1  pixel request valid
plot_ready  in  1  plotter accepts pixel
busy  out  1  high whenever state != IDLE
x_pos  out  X_WIDTH  current sprite top-left x
y_pos  out  Y_WIDTH  current sprite top-left y
missed_tick  out  1  sticky: a tick edge arrived while busy with one already pending

Behaviour:
- Reset (sync, active-high) has priority over everything. Next state is INIT_DRAW. x_pos=X_INIT, y_pos=Y_INIT, dir_x=+1, dir_y=+1. plot_valid=0, pending=0, missed_tick=0, tick_d=0. Pixel counters are 0. A reset mid-step abandons the step; any pixel not yet handshaken is never sent.
- Edge detect: tick_d is the registered tick. edge = tick & ~tick_d & run. A tick held high produces exactly one step.
- States: INIT_DRAW, IDLE, ERASE, MOVE, DRAW.
- INIT_DRAW: draws the sprite at (X_INIT, Y_INIT) in fg_colour, then goes to IDLE.
- IDLE: if edge or pending, go to ERASE next cycle and clear pending. Otherwise stay.
- ERASE: plots SIZE*SIZE pixels in bg_colour at the current position, then goes to MOVE.
- MOVE: one cycle, no plot. Updates position, then goes to DRAW.
- DRAW: plots SIZE*SIZE pixels in fg_colour at the new position, then goes to IDLE.
- Pixel scan (INIT_DRAW/ERASE/DRAW) is row-major from (x_pos+0, y_pos+0): dx 0..SIZE-1 inner, dy 0..SIZE-1 outer.
  - plot_x = x_pos+dx, plot_y = y_pos+dy, both registered.
  - A pixel transfers in a cycle where plot_valid & plot_ready. Counters advance only on a transfer.
  - While plot_valid=1 and plot_ready=0, plot_x, plot_y and plot_colour hold stable.
  - plot_valid drops to 0 in the cycle after the last transfer of a phase.
- MOVE arithmetic, x (y identical using Y_MAX):
  - if dir_x=+1 and x_pos == X_MAX-SIZE+1: set dir_x=-1, x_pos = x_pos-1
  - else if dir_x=-1 and x_pos == 0: set dir_x=+1, x_pos = 1
  - else x_pos = x_pos + dir_x
  - x and y bounce independently in the same MOVE cycle.
  - The sprite never leaves [0, X_MAX]x[0, Y_MAX], and no coordinate wraps.
- Tick while not IDLE (including INIT_DRAW):
  - pending=0: set pending=1.
  - pending=1: drop the edge and set missed_tick=1 (cleared only by reset).
  - An edge in the same cycle IDLE leaves for ERASE is consumed by that step; it is not queued.
- Latency: with plot_ready held 1 and an edge at cycle N, plot_valid goes high at N+1 and the first erase pixel transfers at N+1. The step occupies 2*SIZE*SIZE+1 cycles (N+1..N+2*SIZE*SIZE+1), and busy is high exactly over those cycles.
- run=0 does not abort a step in progress; a pending tick is still serviced.
- Colours are sampled per pixel; fg_colour/bg_colour may change mid-phase.

Test Plan:
- Reset, then plot_ready=1, no tick. Expect 16 pixels (0,0)..(3,3) row-major in fg_colour, then IDLE with busy=0. Pixel count over run is exactly 16.
- From IDLE at (0,0), a one-cycle tick with run=1. Expect 16 bg pixels at (0..3,0..3), one MOVE cycle, then 16 fg pixels at (1..4,1..4). Position ends at (1,1), and busy is high for exactly 33 cycles.
- Preload by stepping to x_pos=156, dir_x=+1 (X_MAX=159, SIZE=4), then tick. Expect x_pos=155, dir_x=-1. Repeat at x_pos=0 moving left: expect x_pos=1. Check the same for y at y_pos=116.
- Toggle plot_ready 1,0,0,1 during ERASE. plot_x/plot_y/plot_colour must stay stable while stalled, and no pixel may be skipped or duplicated.
- Three tick edges during one step. Expect exactly one extra step afterwards, missed_tick=1; a tick held high for 50 cycles yields one step; with run=0, edges yield none.
- Assert reset midway through DRAW. Next cycle plot_valid=0 and busy=1 (INIT_DRAW). The sprite is then redrawn at (0,0) and missed_tick=0.
